// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Receiver frame state
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Bit positions within an 8N1 frame
    localparam logic [3:0] START_IDX     = 4'd0;
    localparam logic [3:0] LAST_DATA_IDX = 4'd8;
    localparam logic [3:0] STOP_IDX      = 4'd9;

    // Clocks per bit period for a given clock and baud rate
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high async input plus a delay flop for falling-edge detection.
// Latency: rxd_s2 lags the pin by 2 cycles; fall asserts in the same cycle rxd_s2 first goes low.
// Backpressure: none; free-running.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd_async,
    output logic rxd_s2,
    output logic fall
);

    logic rxd_s1;
    logic rxd_s3;

    // Synchronise the pin and keep one extra stage of history; reset to line-idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= rxd_async;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    assign fall = rxd_s3 & ~rxd_s2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit 3-sample majority vote, stop-bit check, one-cycle done / frame_err strobes.
// Latency: uart_done about 3 + 9*BPS_CNT + MID+1 cycles after the pin's start edge.
// Backpressure: none; the consumer must take uart_data on the uart_done pulse.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int MID     = BPS_CNT / 2;

    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] SMP_A    = 16'(MID - 1);
    localparam logic [15:0] SMP_B    = 16'(MID);
    localparam logic [15:0] SMP_C    = 16'(MID + 1);

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic        rxd_s2;
    logic        fall;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_idx;
    logic [2:0]  data_pos;
    logic        samp_a;
    logic        samp_b;
    logic        maj;
    logic        wrap;
    logic        at_decide;
    logic        counting;
    logic        stop_decide;
    logic [7:0]  shift_reg;
    logic        done_set;
    logic        err_set;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd_async (uart_rxd),
        .rxd_s2    (rxd_s2),
        .fall      (fall)
    );

    // The third vote is the live synchronised sample, so the decision lands at MID+1
    assign maj         = (samp_a & samp_b) | (samp_a & rxd_s2) | (samp_b & rxd_s2);
    assign wrap        = (clk_cnt == CNT_LAST);
    assign at_decide   = (clk_cnt == SMP_C);
    assign counting    = (state == START) || (state == DATA) || (state == STOP);
    assign stop_decide = (state == STOP) && at_decide && (bit_idx == STOP_IDX);
    assign data_pos    = 3'(bit_idx - 4'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: STOP exits at mid-bit so a zero-gap next frame is caught
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_decide && maj) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (wrap && (bit_idx == LAST_DATA_IDX)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (stop_decide) begin
                    state_nxt = maj ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd_s2) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: busy flag and the stop-bit verdict strobes
    always_comb begin
        rx_busy  = counting;
        done_set = 1'b0;
        err_set  = 1'b0;
        if (stop_decide) begin
            done_set = maj;
            err_set  = ~maj;
        end
    end

    // Bit-period counter and bit index; held at zero outside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= 16'd0;
            bit_idx <= START_IDX;
        end else if (counting) begin
            if (wrap) begin
                clk_cnt <= 16'd0;
                bit_idx <= bit_idx + 4'd1;
            end else begin
                clk_cnt <= clk_cnt + 16'd1;
            end
        end else begin
            clk_cnt <= 16'd0;
            bit_idx <= START_IDX;
        end
    end

    // Capture the two early votes around the bit centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else if (counting) begin
            if (clk_cnt == SMP_A) begin
                samp_a <= rxd_s2;
            end
            if (clk_cnt == SMP_B) begin
                samp_b <= rxd_s2;
            end
        end
    end

    // Assemble data bits LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if ((state == DATA) && at_decide) begin
            shift_reg[data_pos] <= maj;
        end
    end

    // Register strobes; uart_data only moves on a good frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            uart_data <= 8'h00;
        end else begin
            uart_done <= done_set;
            frame_err <= err_set;
            if (done_set) begin
                uart_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 16 clocks per bit.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_uart_recv;

    logic       clk;
    logic       rst_n;
    logic       uart_rxd;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int busy_rise = 0;
    int busy_run = 0;
    int busy_len = 0;
    int done_lat = 0;
    int bad_change = 0;
    logic done_busy = 1'b1;
    logic done_prev_busy = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] done_q[$];

    uart_recv #(
        .CLK_FREQ (1600000),
        .UART_BPS (100000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .uart_done (uart_done),
        .uart_data (uart_data),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (uart_done) begin
            done_q.push_back(uart_data);
            done_cnt++;
            done_lat = cyc - fall_cyc;
            done_busy = rx_busy;
            done_prev_busy = prev_busy;
            if (frame_err) both_cnt++;
        end
        if (frame_err) err_cnt++;
        if (rx_busy && !prev_busy) begin
            busy_rise++;
            busy_run = 0;
        end
        if (rx_busy) busy_run++;
        if (!rx_busy && prev_busy) busy_len = busy_run;
        if (rst_n && !uart_done && (uart_data !== prev_data)) bad_change++;
        prev_busy = rx_busy;
        prev_data = uart_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [7:0] exp);
        if (done_q.size() == 0) begin
            check(tag, 32'hDEAD, 32'(exp));
        end else begin
            check(tag, 32'(done_q.pop_front()), 32'(exp));
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    // Frame with a one-clock inverted spike placed so the synchronised line shows it at clk_cnt==8 of data bit d[2]
    task automatic send_frame_spike(input logic [7:0] d);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                uart_rxd = d[i];
                repeat (9) @(negedge clk);
                uart_rxd = ~d[i];
                @(negedge clk);
                uart_rxd = d[i];
                repeat (6) @(negedge clk);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_done", 32'(uart_done), 32'd0);
        check("rst_data", 32'(uart_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        idle(20);

        // 1: single byte
        send_frame(8'hA5, 1'b1);
        idle(40);
        check("t1_cnt", 32'(done_cnt), 32'd1);
        check_pop("t1_data", 8'hA5);
        check("t1_ferr", 32'(err_cnt), 32'd0);
        check("t1_busy_before", 32'(done_prev_busy), 32'd1);
        check("t1_busy_at_done", 32'(done_busy), 32'd0);
        check("t1_latency", 32'((done_lat >= 155) && (done_lat <= 157)), 32'd1);

        // 2: short low glitch is a false start
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("t2_rise", 32'(busy_rise), 32'd2);
        check("t2_busy_len", 32'(busy_len), 32'd10);
        check("t2_cnt", 32'(done_cnt), 32'd1);
        check("t2_ferr", 32'(err_cnt), 32'd0);
        check("t2_data", 32'(uart_data), 32'hA5);

        // 3: back-to-back frames
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(40);
        check("t3_cnt", 32'(done_cnt), 32'd4);
        check_pop("t3_d0", 8'h3C);
        check_pop("t3_d1", 8'hFF);
        check_pop("t3_d2", 8'h00);
        check("t3_ferr", 32'(err_cnt), 32'd0);

        // 4: framing error, line held low, recovery
        send_frame(8'h12, 1'b0);
        uart_rxd = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_ferr", 32'(err_cnt), 32'd1);
        check("t4_busy_low", 32'(rx_busy), 32'd0);
        check("t4_cnt_low", 32'(done_cnt), 32'd4);
        check("t4_data_held", 32'(uart_data), 32'h00);
        idle(20);
        send_frame(8'h34, 1'b1);
        idle(40);
        check("t4_cnt", 32'(done_cnt), 32'd5);
        check_pop("t4_data", 8'h34);
        check("t4_ferr_after", 32'(err_cnt), 32'd1);
        check("t4_exclusive", 32'(both_cnt), 32'd0);

        // 5: mid-bit spike rejected by majority
        send_frame_spike(8'h81);
        idle(40);
        check("t5_cnt", 32'(done_cnt), 32'd6);
        check_pop("t5_data", 8'h81);

        // 6: reset during bit 5 of 0x77
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i));
        uart_rxd = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_data", 32'(uart_data), 32'h00);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        check("t6_rst_done", 32'(uart_done), 32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        idle(30);
        check("t6_no_pulse", 32'(done_cnt), 32'd6);
        send_frame(8'h5A, 1'b1);
        idle(40);
        check("t6_cnt", 32'(done_cnt), 32'd7);
        check_pop("t6_data", 8'h5A);
        check("t6_ferr", 32'(err_cnt), 32'd1);
        check("data_stable", 32'(bad_change), 32'd0);
        check("queue_empty", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
